// File: rtl/multi_btn_debouncer.sv
// Multi-channel button debouncer with synchroniser, edge pulses
// and a long-press pulse per channel.
module multi_btn_debouncer #(
   parameter int N_BTN       = 3,
   parameter int COUNT_SIZE  = 10000,
   parameter int SYNC_STAGES = 2,
   parameter int LONG_COUNT  = 50000000
) (
   input  logic             clk_100Mhz,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_in,
   output logic [N_BTN-1:0] btn_out,
   output logic [N_BTN-1:0] btn_rise,
   output logic [N_BTN-1:0] btn_fall,
   output logic [N_BTN-1:0] btn_long
);

   localparam int CW = $clog2(COUNT_SIZE);
   localparam int HW = $clog2(LONG_COUNT + 1);

   localparam logic [CW-1:0] CNT_LAST = CW'(COUNT_SIZE - 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_COUNT);
   localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_COUNT - 1);

   genvar g;
   generate
      for (g = 0; g < N_BTN; g++) begin : g_chan
         logic [SYNC_STAGES-1:0] sync_q;
         logic [CW-1:0]          db_cnt;
         logic [HW-1:0]          hold_cnt;
         logic                   out_q;
         logic                   rise_q;
         logic                   fall_q;
         logic                   long_q;
         logic                   s;
         logic                   differs;
         logic                   accept;

         // Decide whether the synchronised level is accepted this cycle
         always_comb begin
            s       = sync_q[SYNC_STAGES-1];
            differs = (s != out_q);
            accept  = differs && (db_cnt == CNT_LAST);
         end

         // Synchroniser chain: bit 0 samples the raw pin
         always_ff @(posedge clk_100Mhz or posedge rst) begin
            if (rst) begin
               sync_q <= '0;
            end else begin
               sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in[g]};
            end
         end

         // Debounce counter, accepted level and edge pulses
         always_ff @(posedge clk_100Mhz or posedge rst) begin
            if (rst) begin
               db_cnt <= '0;
               out_q  <= 1'b0;
               rise_q <= 1'b0;
               fall_q <= 1'b0;
            end else begin
               if (!differs || accept) begin
                  db_cnt <= '0;
               end else begin
                  db_cnt <= db_cnt + CW'(1);
               end
               if (accept) begin
                  out_q <= s;
               end
               rise_q <= accept & s;
               fall_q <= accept & ~s;
            end
         end

         // Hold counter saturates so a press yields one long pulse
         always_ff @(posedge clk_100Mhz or posedge rst) begin
            if (rst) begin
               hold_cnt <= '0;
               long_q   <= 1'b0;
            end else begin
               if (!out_q) begin
                  hold_cnt <= '0;
               end else if (hold_cnt != HOLD_MAX) begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
               long_q <= out_q && (hold_cnt == HOLD_PRE);
            end
         end

         assign btn_out[g]  = out_q;
         assign btn_rise[g] = rise_q;
         assign btn_fall[g] = fall_q;
         assign btn_long[g] = long_q;
      end
   endgenerate

endmodule

// File: tb/tb_multi_btn_debouncer.sv
// Bench for multi_btn_debouncer: directed scenarios then random
// button activity, checked against a cycle-level behavioural model.
module tb_multi_btn_debouncer;

   localparam int N  = 3;
   localparam int CS = 4;
   localparam int SS = 2;
   localparam int LC = 8;

   logic         clk_100Mhz = 1'b0;
   logic         rst;
   logic [N-1:0] btn_in;
   logic [N-1:0] btn_out;
   logic [N-1:0] btn_rise;
   logic [N-1:0] btn_fall;
   logic [N-1:0] btn_long;

   int tests = 0;
   int fails = 0;

   // reference model state
   bit           m_sync [N][SS];
   int           m_diff [N];
   int           m_high [N];
   logic [N-1:0] m_out, m_rise, m_fall, m_long;

   multi_btn_debouncer #(
      .N_BTN(N), .COUNT_SIZE(CS), .SYNC_STAGES(SS), .LONG_COUNT(LC)
   ) dut (
      .clk_100Mhz(clk_100Mhz),
      .rst(rst),
      .btn_in(btn_in),
      .btn_out(btn_out),
      .btn_rise(btn_rise),
      .btn_fall(btn_fall),
      .btn_long(btn_long)
   );

   always #5 clk_100Mhz = ~clk_100Mhz;

   task automatic chk(input string tag, input logic [N-1:0] obs,
                      input logic [N-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         for (int k = 0; k < SS; k++) m_sync[i][k] = 1'b0;
         m_diff[i] = 0;
         m_high[i] = 0;
      end
      m_out  = '0;
      m_rise = '0;
      m_fall = '0;
      m_long = '0;
   endtask

   // One rising edge: level seen by the debouncer is the pin value
   // from SS edges ago; it must differ CS edges running to be taken.
   task automatic model_edge(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) begin
         bit s;
         s = m_sync[i][SS-1];
         for (int k = SS-1; k > 0; k--) m_sync[i][k] = m_sync[i][k-1];
         m_sync[i][0] = v[i];
         m_rise[i] = 1'b0;
         m_fall[i] = 1'b0;
         if (m_out[i]) begin
            m_high[i]++;
            m_long[i] = (m_high[i] == LC);
         end else begin
            m_high[i] = 0;
            m_long[i] = 1'b0;
         end
         if (s != m_out[i]) begin
            m_diff[i]++;
            if (m_diff[i] == CS) begin
               m_out[i]  = s;
               m_rise[i] = s;
               m_fall[i] = !s;
               m_diff[i] = 0;
            end
         end else begin
            m_diff[i] = 0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".out"},  btn_out,  m_out);
      chk({tag, ".rise"}, btn_rise, m_rise);
      chk({tag, ".fall"}, btn_fall, m_fall);
      chk({tag, ".long"}, btn_long, m_long);
   endtask

   task automatic step(input logic [N-1:0] v);
      btn_in = v;
      @(posedge clk_100Mhz);
      model_edge(v);
      #1;
      check_all("step");
   endtask

   task automatic steps(input logic [N-1:0] v, input int n);
      for (int j = 0; j < n; j++) step(v);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".out"},  btn_out,  '0);
      chk({tag, ".rise"}, btn_rise, '0);
      chk({tag, ".fall"}, btn_fall, '0);
      chk({tag, ".long"}, btn_long, '0);
   endtask

   // Asynchronous reset pulse mid-cycle, released between edges
   task automatic pulse_reset();
      rst = 1'b1;
      #1;
      check_zero("rst_async");
      model_reset();
      repeat (2) @(posedge clk_100Mhz);
      #1;
      check_zero("rst_held");
      rst = 1'b0;
   endtask

   initial begin
      rst    = 1'b1;
      btn_in = '0;
      model_reset();
      #2;
      check_zero("reset");
      repeat (2) @(posedge clk_100Mhz);
      #1;
      rst = 1'b0;
      steps(3'b000, 4);

      // clean press on channel 0
      steps(3'b001, 5);
      chk("press_lat5", btn_out, 3'b000);
      step(3'b001);
      chk("press_lat6", btn_out, 3'b001);
      chk("press_rise", btn_rise, 3'b001);
      step(3'b001);
      chk("press_rise_1cyc", btn_rise, 3'b000);
      steps(3'b000, 16);

      // bounce on channel 1
      steps(3'b010, 3);
      step(3'b000);
      steps(3'b010, 5);
      chk("bounce_lat5", btn_out, 3'b000);
      step(3'b010);
      chk("bounce_lat6", btn_out, 3'b010);
      steps(3'b000, 16);

      // long press on channel 2
      steps(3'b100, 6);
      chk("long_rise", btn_rise, 3'b100);
      steps(3'b100, 7);
      chk("long_early", btn_long, 3'b000);
      step(3'b100);
      chk("long_pulse", btn_long, 3'b100);
      steps(3'b100, 12);
      steps(3'b000, 5);
      chk("long_fall5", btn_fall, 3'b000);
      step(3'b000);
      chk("long_fall6", btn_fall, 3'b100);
      steps(3'b000, 12);

      // short press on channel 0
      steps(3'b001, 10);
      steps(3'b000, 16);

      // channels 0 and 2 two cycles apart
      steps(3'b001, 2);
      steps(3'b101, 4);
      chk("indep_ch0", btn_rise, 3'b001);
      steps(3'b101, 2);
      chk("indep_ch2", btn_rise, 3'b100);
      steps(3'b101, 12);
      steps(3'b000, 16);

      // reset mid-count, then mid-hold
      steps(3'b001, 3);
      pulse_reset();
      steps(3'b001, 5);
      chk("rst_relat5", btn_out, 3'b000);
      step(3'b001);
      chk("rst_rerise", btn_rise, 3'b001);
      steps(3'b001, 4);
      pulse_reset();
      steps(3'b001, 6);
      chk("rst_rerise2", btn_rise, 3'b001);
      steps(3'b001, 7);
      chk("rst_nostale", btn_long, 3'b000);
      step(3'b001);
      chk("rst_long", btn_long, 3'b001);
      steps(3'b000, 16);

      // random activity; occasional mid-run reset
      begin
         logic [N-1:0] v;
         v = '0;
         for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < N; i++) begin
               if ($urandom_range(0, 7) == 0) v[i] = ~v[i];
            end
            if (t == 700) pulse_reset();
            step(v);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
